// File: rtl/lzx_vote_collector.sv
// lzx_vote_collector: debounced three-judge vote collection session front-end for the lzx_rulingtable.
// Optional build macro LZX_VOID_ON_TIMEOUT_EN: a window that expires without all three votes
// voids the session and raises void_flag alongside done.
module lzx_vote_collector #(
  parameter int DEB_CYCLES    = 4,
  parameter int WINDOW_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic             btn_c,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             verdict,
  output logic [2:0]       voted,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef LZX_VOID_ON_TIMEOUT_EN
  ,
  output logic             void_flag
`endif
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int WW = $clog2(WINDOW_CYCLES);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EVAL, S_DONE} state_t;
  state_t state, state_nx;
  logic [2:0] sync1, sync2, press, voted_nx;
  logic [WW-1:0] win;
  logic close, void_close;
  // two-flop synchroniser for the raw asynchronous buttons
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_c, btn_b, btn_a};
      sync2 <= sync1;
    end
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DW-1:0] cnt;
    // run length of synced-high samples, saturating at DEB_CYCLES; any low sample restarts it
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= !sync2[i] ? '0 : (cnt == DW'(DEB_CYCLES) ? cnt : cnt + DW'(1));
    // the debounced level rises exactly on the sample that completes the run
    assign press[i] = sync2[i] && cnt == DW'(DEB_CYCLES - 1);
  end
  assign voted_nx = voted | press;
  assign close = state == S_COLLECT && (win == WW'(WINDOW_CYCLES - 1) || voted == 3'b111);
`ifdef LZX_VOID_ON_TIMEOUT_EN
  assign void_close = close && voted_nx != 3'b111;
`else
  assign void_close = 1'b0;
`endif
  assign busy = state == S_COLLECT || state == S_EVAL;
  assign done = state == S_DONE;
  // session state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  // session sequencing: open on start, close on full vote or window expiry, one-cycle eval and done
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    state_nx = start ? S_COLLECT : S_IDLE;
      S_COLLECT: state_nx = close ? (void_close ? S_DONE : S_EVAL) : S_COLLECT;
      S_EVAL:    state_nx = S_DONE;
      default:   state_nx = S_IDLE;
    endcase
  end
  // vote collection, table drive, verdict capture and saturating tallies
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      win      <= '0;
      voted    <= '0;
      {C, B, A} <= '0;
      verdict  <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        voted <= '0;
        win   <= '0;
      end
      if (state == S_COLLECT) begin
        voted <= voted_nx;
        win   <= win + WW'(1);
      end
      if (close && !void_close) {C, B, A} <= voted_nx;
      if (state == S_EVAL) begin
        verdict <= Y;
        if (Y) pass_cnt <= &pass_cnt ? pass_cnt : pass_cnt + CNT_W'(1);
        else fail_cnt <= &fail_cnt ? fail_cnt : fail_cnt + CNT_W'(1);
      end
    end
`ifdef LZX_VOID_ON_TIMEOUT_EN
  // void marker is high only during the DONE cycle of a voided session
  always_ff @(posedge clk or posedge rst)
    if (rst) void_flag <= 1'b0;
    else void_flag <= void_close;
`endif
endmodule
